// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath slice.
// estado encodings are common with the entry FSM that drives this bank.
package calc_pkg;

  localparam logic [2:0] EST_A   = 3'd0;
  localparam logic [2:0] EST_B   = 3'd1;
  localparam logic [2:0] EST_OP  = 3'd2;
  localparam logic [2:0] EST_RES = 3'd3;
  localparam logic [2:0] EST_CLR = 3'd4;

  // ALU request sequencer
  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/digit_shift_reg.sv
// Digit-entry shift register: each push shifts the held value left by one
// digit and inserts din in the least-significant digit, until DIGITS are held.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous clear (wins over push)
//   push       append din when not full
//   din        digit to append
//   value      held digits, last-entered in the LS digit
//   count      number of digits held (0..DIGITS)
module digit_shift_reg #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [DIGIT_W-1:0]           din,
  output logic [DIGITS*DIGIT_W-1:0]    value,
  output logic [$clog2(DIGITS+1)-1:0]  count
);

  localparam int CNT_W = $clog2(DIGITS+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (push && (count < FULL)) begin
      value <= {value[DIGITS*DIGIT_W-DIGIT_W-1:0], din};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/operand_bank.sv
// Datapath end of the calculator entry FSM: collects operand digits, the
// operation code, runs the start/done handshake with the ALU and drives the
// registered word for the main display.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   trigger_1/trigger_2      append digit_in to operand A / B
//   trigger_op               capture op_in
//   reset_a_reg              synchronous clear of all bank state
//   estado                   entry phase from the entry FSM
//   digit_in, op_in          switch inputs
//   alu_result, alu_done     ALU answer and completion
//   operand_a/b, a/b_count   operand registers and digit counts
//   op_code                  captured operation
//   alu_start                one-cycle ALU request
//   result, result_valid     latched ALU answer
//   disp_value               registered display word
module operand_bank
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int OP_W    = 2,
  parameter int RES_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trigger_1,
  input  logic                         trigger_2,
  input  logic                         trigger_op,
  input  logic                         reset_a_reg,
  input  logic [2:0]                   estado,
  input  logic [DIGIT_W-1:0]           digit_in,
  input  logic [OP_W-1:0]              op_in,
  input  logic [RES_W-1:0]             alu_result,
  input  logic                         alu_done,
  output logic [DIGITS*DIGIT_W-1:0]    operand_a,
  output logic [DIGITS*DIGIT_W-1:0]    operand_b,
  output logic [OP_W-1:0]              op_code,
  output logic [$clog2(DIGITS+1)-1:0]  a_count,
  output logic [$clog2(DIGITS+1)-1:0]  b_count,
  output logic                         alu_start,
  output logic [RES_W-1:0]             result,
  output logic                         result_valid,
  output logic [RES_W-1:0]             disp_value
);

  seq_state_t state, state_nxt;
  logic [2:0] estado_q;
  logic       res_entry;

  digit_shift_reg #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_reg_a (
    .clk   (clk),
    .rst   (rst),
    .clr   (reset_a_reg),
    .push  (trigger_1),
    .din   (digit_in),
    .value (operand_a),
    .count (a_count)
  );

  digit_shift_reg #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_reg_b (
    .clk   (clk),
    .rst   (rst),
    .clr   (reset_a_reg),
    .push  (trigger_2),
    .din   (digit_in),
    .value (operand_b),
    .count (b_count)
  );

  // A new ALU request starts only on entry into the result phase.
  assign res_entry = (estado == EST_RES) && (estado_q != EST_RES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (reset_a_reg) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (res_entry) state_nxt = START;
      START: state_nxt = WAIT;
      // Completion takes priority over an abort seen in the same cycle.
      WAIT: begin
        if (alu_done)                  state_nxt = DONE;
        else if (estado != EST_RES)    state_nxt = IDLE;
      end
      DONE:  if (estado != EST_RES) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_start = (state == START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_code      <= '0;
      estado_q     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      disp_value   <= '0;
    end else if (reset_a_reg) begin
      op_code      <= '0;
      estado_q     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      disp_value   <= '0;
    end else begin
      estado_q <= estado;
      if (trigger_op) op_code <= op_in;

      if ((state == WAIT) && alu_done) begin
        result       <= alu_result;
        result_valid <= 1'b1;
      end else if ((state == DONE) && (estado != EST_RES)) begin
        result_valid <= 1'b0;
      end

      unique case (estado)
        EST_A:   disp_value <= RES_W'(operand_a);
        EST_B:   disp_value <= RES_W'(operand_b);
        EST_OP:  disp_value <= RES_W'(op_code);
        EST_RES: disp_value <= result_valid ? result : '0;
        default: disp_value <= '0;
      endcase
    end
  end

endmodule
